// File: rtl/traffic_pkg.sv
// Shared types and constants for the main/side-street light sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG   = 3'd4,
    SGX  = 3'd5,
    SY   = 3'd6
  } state_t;

  // Lamp encodings are {R,Y,G}, one-hot.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int T_BASE_DEF = 6;
  localparam int T_EXT_DEF  = 3;
  localparam int T_YEL_DEF  = 2;

endpackage

// File: rtl/walk_request_latch.sv
// Holds a pedestrian request until the sequencer enters the walk phase.
// Latency: 1 cycle set/clear; backpressure: none, requests seen during a walk phase are dropped.
module walk_request_latch (
  input  logic clk,
  input  logic Reset_n,
  input  logic walk_request,
  input  logic clear,
  input  logic in_walk,
  output logic walk_pending
);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      walk_pending <= 1'b0;
    end else if (clear) begin
      walk_pending <= 1'b0;
    end else if (walk_request && !in_walk) begin
      walk_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side-street light sequencer driving a countdown timer via Value/start_timer/expired.
// Latency: phase = Value timer seconds + up to 3 clk; backpressure: none, expired is ignored until armed.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int T_BASE = T_BASE_DEF,
  parameter int T_EXT  = T_EXT_DEF,
  parameter int T_YEL  = T_YEL_DEF
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [2:0] state_dbg
);

  if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 || T_YEL < 1 || T_YEL > 15)
  begin : g_bad_interval
    $error("traffic_light_fsm: every interval must lie in 1..15");
  end

  state_t     state;
  state_t     nxt;
  logic [3:0] nxt_value;
  logic [1:0] arm_cnt;
  logic       started;
  logic       advance;
  logic       walk_pending;

  function automatic logic [2:0] main_of(input state_t s);
    case (s)
      MG1, MG2: main_of = LAMP_G;
      MY:       main_of = LAMP_Y;
      default:  main_of = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_of(input state_t s);
    case (s)
      SG, SGX: side_of = LAMP_G;
      SY:      side_of = LAMP_Y;
      default: side_of = LAMP_R;
    endcase
  endfunction

  always_comb begin
    nxt       = state;
    nxt_value = 4'(T_BASE);
    case (state)
      MG1:     nxt = MG2;
      MG2:     nxt = MY;
      MY:      nxt = walk_pending ? WALK : SG;
      WALK:    nxt = SG;
      SG:      nxt = sensor ? SGX : SY;
      SGX:     nxt = SY;
      default: nxt = MG1;
    endcase
    case (nxt)
      MG2:       nxt_value = sensor ? 4'(T_EXT) : 4'(T_BASE);
      MY, SY:    nxt_value = 4'(T_YEL);
      WALK, SGX: nxt_value = 4'(T_EXT);
      default:   nxt_value = 4'(T_BASE);
    endcase
  end

  // arm_cnt masks expired for the two edges after each load, covering timer reload latency.
  assign advance = started && (arm_cnt == 2'd0) && expired;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= MG1;
      Value       <= 4'd0;
      start_timer <= 1'b0;
      arm_cnt     <= 2'd0;
      started     <= 1'b0;
      main_lights <= LAMP_G;
      side_lights <= LAMP_R;
      walk_lamp   <= 1'b0;
    end else if (!started) begin
      started     <= 1'b1;
      Value       <= 4'(T_BASE);
      start_timer <= 1'b1;
      arm_cnt     <= 2'd2;
    end else if (advance) begin
      state       <= nxt;
      Value       <= nxt_value;
      start_timer <= 1'b1;
      arm_cnt     <= 2'd2;
      main_lights <= main_of(nxt);
      side_lights <= side_of(nxt);
      walk_lamp   <= (nxt == WALK);
    end else begin
      start_timer <= 1'b0;
      if (arm_cnt != 2'd0) arm_cnt <= arm_cnt - 2'd1;
    end
  end

  assign state_dbg = state;

  walk_request_latch u_latch (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .walk_request (walk_request),
    .clear        (advance && (nxt == WALK)),
    .in_walk      (state == WALK),
    .walk_pending (walk_pending)
  );

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: expired is driven directly, so each armed phase lasts 3 clk.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int ncyc;

  traffic_light_fsm dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .sensor       (sensor),
    .walk_request (walk_request),
    .expired      (expired),
    .Value        (Value),
    .start_timer  (start_timer),
    .main_lights  (main_lights),
    .side_lights  (side_lights),
    .walk_lamp    (walk_lamp),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic [3:0] val,
                               input logic [2:0] ml, input logic [2:0] sl, input logic wl);
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".value"}, 32'(Value), 32'(val));
    check({tag, ".main"}, 32'(main_lights), 32'(ml));
    check({tag, ".side"}, 32'(side_lights), 32'(sl));
    check({tag, ".walk"}, 32'(walk_lamp), 32'(wl));
  endtask

  // Steps negedges until a start_timer pulse is seen (bounded), then checks the new phase.
  task automatic expect_entry(input string tag, input logic [2:0] st, input logic [3:0] val,
                              input logic [2:0] ml, input logic [2:0] sl, input logic wl,
                              output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (start_timer !== 1'b1 && n < 20);
    check({tag, ".start"}, 32'(start_timer), 32'd1);
    check_outputs(tag, st, val, ml, sl, wl);
  endtask

  initial begin
    Reset_n      = 1'b0;
    sensor       = 1'b0;
    walk_request = 1'b0;
    expired      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.start", 32'(start_timer), 32'd0);
    check_outputs("rst", 3'd0, 4'd0, LAMP_G, LAMP_R, 1'b0);
    check("rst.pending", 32'(dut.u_latch.walk_pending), 32'd0);

    // Release: first edge loads T_BASE into MG1; with expired low nothing advances.
    Reset_n = 1'b1;
    @(negedge clk);
    check("rel.start", 32'(start_timer), 32'd1);
    check_outputs("rel", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0);
    repeat (5) @(negedge clk);
    check("hold.start", 32'(start_timer), 32'd0);
    check("hold.state", 32'(state_dbg), 32'(MG1));

    // Plain cycle, sensor low, no walk requests.
    expired = 1'b1;
    expect_entry("c1.mg2", MG2, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    check("c1.mg2.cyc", 32'(ncyc), 32'd1);
    expect_entry("c1.my", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    expect_entry("c1.sg", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);
    expect_entry("c1.sy", SY, 4'd2, LAMP_R, LAMP_Y, 1'b0, ncyc);
    expect_entry("c1.mg1", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);

    // Sensor held high: extended MG2 load and SGX inserted; every phase exactly 3 clk.
    sensor = 1'b1;
    expect_entry("c2.mg2", MG2, 4'd3, LAMP_G, LAMP_R, 1'b0, ncyc);
    check("c2.mg2.cyc", 32'(ncyc), 32'd3);
    expect_entry("c2.my", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    check("c2.my.cyc", 32'(ncyc), 32'd3);
    expect_entry("c2.sg", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);
    check("c2.sg.cyc", 32'(ncyc), 32'd3);
    expect_entry("c2.sgx", SGX, 4'd3, LAMP_R, LAMP_G, 1'b0, ncyc);
    check("c2.sgx.cyc", 32'(ncyc), 32'd3);
    expect_entry("c2.sy", SY, 4'd2, LAMP_R, LAMP_Y, 1'b0, ncyc);
    check("c2.sy.cyc", 32'(ncyc), 32'd3);
    expect_entry("c2.mg1", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    check("c2.mg1.cyc", 32'(ncyc), 32'd3);
    sensor = 1'b0;

    // One-cycle walk pulse in MG1: WALK follows MY.
    walk_request = 1'b1;
    @(negedge clk);
    walk_request = 1'b0;
    check("c3.pending", 32'(dut.u_latch.walk_pending), 32'd1);
    expect_entry("c3.mg2", MG2, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    expect_entry("c3.my", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    expect_entry("c3.walk", WALK, 4'd3, LAMP_R, LAMP_R, 1'b1, ncyc);
    check("c3.walk.pending", 32'(dut.u_latch.walk_pending), 32'd0);
    expect_entry("c3.sg", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);
    expect_entry("c3.sy", SY, 4'd2, LAMP_R, LAMP_Y, 1'b0, ncyc);
    expect_entry("c3.mg1", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);

    // Request held from MY entry through the WALK exit edge: exactly one WALK.
    expect_entry("c4.mg2", MG2, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    expect_entry("c4.my", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    walk_request = 1'b1;
    expect_entry("c4.walk", WALK, 4'd3, LAMP_R, LAMP_R, 1'b1, ncyc);
    expect_entry("c4.sg", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);
    walk_request = 1'b0;
    check("c4.sg.pending", 32'(dut.u_latch.walk_pending), 32'd0);
    expect_entry("c4.sy", SY, 4'd2, LAMP_R, LAMP_Y, 1'b0, ncyc);
    expect_entry("c4.mg1", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    expect_entry("c4.mg2b", MG2, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    expect_entry("c4.myb", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    expect_entry("c4.sgb", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);

    // Reset mid-SG with a fresh request pending: everything returns to reset values at once.
    walk_request = 1'b1;
    @(negedge clk);
    walk_request = 1'b0;
    check("c5.pending", 32'(dut.u_latch.walk_pending), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("c5.rst.start", 32'(start_timer), 32'd0);
    check_outputs("c5.rst", 3'd0, 4'd0, LAMP_G, LAMP_R, 1'b0);
    check("c5.rst.pending", 32'(dut.u_latch.walk_pending), 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    check("c5.rel.start", 32'(start_timer), 32'd1);
    check_outputs("c5.rel", MG1, 4'd6, LAMP_G, LAMP_R, 1'b0);
    expect_entry("c5.mg2", MG2, 4'd6, LAMP_G, LAMP_R, 1'b0, ncyc);
    check("c5.mg2.cyc", 32'(ncyc), 32'd3);
    expect_entry("c5.my", MY, 4'd2, LAMP_Y, LAMP_R, 1'b0, ncyc);
    expect_entry("c5.sg", SG, 4'd6, LAMP_R, LAMP_G, 1'b0, ncyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Main/side-street traffic light sequencer with a latched pedestrian walk request. It drives the countdown timer: it loads an interval with `Value` and pulses `start_timer`, then advances phase when the timer reports `expired`. It sits between the input synchronizers (`sensor`, `walk_request`) and the lamp drivers. It is the initiator side of the timer's `Value`/`start_timer`/`expired` interface.

## Interface
- `T_BASE`, default 6: base green interval, in seconds.
- `T_EXT`, default 3: extension interval and walk interval, in seconds.
- `T_YEL`, default 2: yellow interval, in seconds.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `sensor`  in  1: side-street traffic present; already synchronized to `clk`.
- `walk_request`  in  1: pedestrian button; already synchronized; a level or a one-cycle pulse.
- `expired`  in  1: timer countdown finished (level).
- `Value`  out  4: interval to load into the timer; registered.
- `start_timer`  out  1: one-cycle pulse; the timer loads `Value`.
- `main_lights`  out  3: main-street lamps, {R,Y,G}, one-hot.
- `side_lights`  out  3: side-street lamps, {R,Y,G}, one-hot.
- `walk_lamp`  out  1: pedestrian walk indication.
- `state_dbg`  out  3: current state encoding.

## Operation
- States, in order, with the interval loaded on entry:
  - `MG1`: main G, side R. Interval `T_BASE`.
  - `MG2`: main G, side R. Interval `T_EXT` if `sensor`=1 at the entry edge, else `T_BASE`.
  - `MY`: main Y, side R. Interval `T_YEL`.
  - `WALK`: main R, side R, `walk_lamp`=1. Interval `T_EXT`. Entered only if a walk request is pending.
  - `SG`: main R, side G. Interval `T_BASE`.
  - `SGX`: main R, side G. Interval `T_EXT`. Entered from `SG` only if `sensor`=1 at the exit edge; otherwise `SG` goes straight to `SY`.
  - `SY`: main R, side Y. Interval `T_YEL`.
- Transitions: `MG1`→`MG2`→`MY`→(`WALK` if pending, else `SG`)→`SG`→(`SGX`|`SY`)→`SY`→`MG1`. `WALK`→`SG`.
- A state transition is taken only when `expired`=1 and the transition is armed (see Timing).
- Walk latch:
  - Any cycle with `walk_request`=1 sets `walk_pending`.
  - `walk_pending` clears on the edge that enters `WALK`. Clear wins over a simultaneous set.
  - A request asserted while in `WALK` is dropped.
- Lamp outputs are decoded from the state register only; they never glitch between phases.
- Width rule: `T_*` must fit in 4 bits (1..15); this is an elaboration-time check. Value 0 is illegal.

## Timing
- On every state entry, at edge k: `Value`←new interval and `start_timer`←1. At edge k+1: `start_timer`←0.
- `expired` is ignored at edges k+1 and k+2, to cover the timer's reload latency. The FSM arms from edge k+3 onward.
- Phase length is `Value` timer seconds plus at most 3 `clk` cycles.
- A stale `expired`=1 held over from the previous interval never causes a double advance.
- Reset values:
  - State `MG1`.
  - `Value`=0, `start_timer`=0.
  - `main_lights`=G (3'b001), `side_lights`=R (3'b100), `walk_lamp`=0.
  - `walk_pending`=0, `state_dbg`=0.
- First edge after `Reset_n` deasserts: `start_timer`=1 with `Value`=`T_BASE`. This is treated as an entry into `MG1`.
- Reset asserted mid-phase: all outputs return to their reset values immediately (asynchronous), and any pending walk is discarded.
- `sensor` is sampled only at the transition edges listed above. Changes within a phase have no effect.

## Structure
- Package `traffic_pkg` holds:
  - the state enum (`MG1`=0, `MG2`=1, `MY`=2, `WALK`=3, `SG`=4, `SGX`=5, `SY`=6);
  - lamp constants `LAMP_R`/`LAMP_Y`/`LAMP_G`;
  - the default interval constants.
- Sub-module `walk_request_latch` implements the set/clear/drop rules. Its ports are `clk`, `Reset_n`, `walk_request`, `clear`, `in_walk`, and `walk_pending`.
- Everything else, including the next-state logic, interval select, arm counter, and lamp decode, stays in the top module.

## Test plan
- Reset release with `sensor`=0 and no walk requests:
  - Edge 1 after release gives `start_timer` pulse with `Value`=6.
  - Full cycle runs `MG1`(6)→`MG2`(6)→`MY`(2)→`SG`(6)→`SY`(2)→`MG1`.
  - `walk_lamp` stays 0 throughout.
- `sensor`=1 held:
  - `MG2` loads `Value`=3.
  - `SG` is followed by `SGX` with `Value`=3, then `SY`.
- One-cycle `walk_request` during `MG1`:
  - After `MY`, the FSM enters `WALK` with `Value`=3, both streets R, `walk_lamp`=1, then `SG`.
  - `walk_pending` is 0 after the `WALK` entry.
- `walk_request` held high across the `MY`→`WALK` edge and through `WALK`:
  - Exactly one `WALK` phase occurs.
  - No second `WALK` in the next cycle unless a new request arrives after `WALK` exits.
- `expired` held at 1 continuously:
  - Each state lasts exactly 3 `clk` cycles.
  - One `start_timer` pulse per state; no skipped states.
- `Reset_n` pulled low mid-`SG`:
  - Outputs are immediately main G / side R, `Value`=0, `start_timer`=0.
  - After release, the sequence restarts at `MG1` with `Value`=6.
